// File: rtl/sram_chunk_reader.sv
// SRAM front end: owns the single-port macro pins, serves writes and streams each read word out
// as up to NUM_CHUNKS chunks (LSB first). Define SRAM_Q_PIPE_EN to register sram_q before capture.
module sram_chunk_reader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CHUNK_W    = 9,
    parameter int unsigned NUM_CHUNKS = 2,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ack,
    input  logic                              rd_req,
    input  logic [ADDR_W-1:0]                 rd_addr,
    input  logic [$clog2(NUM_CHUNKS+1)-1:0]   rd_chunks,
    output logic                              rd_ack,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHUNK_W-1:0]                out_data,
    output logic                              out_last,
    output logic                              sram_csn,
    output logic                              sram_wen,
    output logic [ADDR_W-1:0]                 sram_a,
    output logic [DATA_W-1:0]                 sram_d,
    input  logic [DATA_W-1:0]                 sram_q,
    input  logic                              sram_ry
);

    localparam int unsigned CNT_W  = $clog2(NUM_CHUNKS + 1);
    localparam int unsigned USED_W = NUM_CHUNKS * CHUNK_W;
`ifdef SRAM_Q_PIPE_EN
    localparam int unsigned WAIT_CYC = RD_LAT + 1;
`else
    localparam int unsigned WAIT_CYC = RD_LAT;
`endif
    localparam int unsigned WCNT_W = $clog2(WAIT_CYC + 1);

    if (USED_W > DATA_W) begin : g_bad_chunks
        $error("sram_chunk_reader: NUM_CHUNKS*CHUNK_W exceeds DATA_W");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("sram_chunk_reader: RD_LAT must be at least 1");
    end
    if (USED_W < DATA_W) begin : g_hi
        logic unused_q_hi;
        assign unused_q_hi = ^sram_q[DATA_W-1:USED_W];
    end

    typedef enum logic [2:0] {IDLE, WRITE, ISSUE, WAIT, STREAM} state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    eff_q, eff_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [USED_W-1:0]   buf_q, buf_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_ack_q, rd_ack_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [CHUNK_W-1:0]  out_data_q, out_data_d;
    logic                csn_q, csn_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
    logic [DATA_W-1:0]   sram_d_q, sram_d_d;
    logic [USED_W-1:0]   cap_src;
    logic [CHUNK_W-1:0]  next_chunk;
    logic [CNT_W-1:0]    rd_eff;

`ifdef SRAM_Q_PIPE_EN
    logic [USED_W-1:0] q_pipe_q, q_pipe_d;

    always_comb begin
        q_pipe_d = sram_q[USED_W-1:0];
        cap_src  = q_pipe_q;
    end

    always_ff @(posedge clk) begin
        if (rst) q_pipe_q <= '0;
        else     q_pipe_q <= q_pipe_d;
    end
`else
    always_comb cap_src = sram_q[USED_W-1:0];
`endif

    always_comb begin
        rd_eff = rd_chunks;
        if (rd_chunks == '0 || rd_chunks > CNT_W'(NUM_CHUNKS)) rd_eff = CNT_W'(NUM_CHUNKS);
    end

    always_comb begin
        next_chunk = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (CNT_W'(i) == idx_q + CNT_W'(1)) next_chunk = buf_q[i*CHUNK_W +: CHUNK_W];
        end
    end

    // Pins follow state_q by one edge, so WAIT covers the csn-low issue cycle plus WAIT_CYC cycles.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        eff_d       = eff_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        sram_a_d    = sram_a_q;
        sram_d_d    = sram_d_q;
        case (state_q)
            IDLE: begin
                if (sram_ry) begin
                    if (wr_en) begin
                        addr_d   = wr_addr;
                        wdata_d  = wr_data;
                        wr_ack_d = 1'b1;
                        state_d  = WRITE;
                    end else if (rd_req) begin
                        addr_d   = rd_addr;
                        eff_d    = rd_eff;
                        rd_ack_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            WRITE: begin
                csn_d    = 1'b0;
                wen_d    = 1'b0;
                sram_a_d = addr_q;
                sram_d_d = wdata_q;
                state_d  = IDLE;
            end
            ISSUE: begin
                csn_d      = 1'b0;
                sram_a_d   = addr_q;
                wait_cnt_d = WCNT_W'(WAIT_CYC);
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    buf_d       = cap_src;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = cap_src[CHUNK_W-1:0];
                    out_last_d  = (eff_q == CNT_W'(1));
                    state_d     = STREAM;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCNT_W'(1);
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = idx_q + CNT_W'(1);
                        out_data_d = next_chunk;
                        out_last_d = (idx_q + CNT_W'(1)) == (eff_q - CNT_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            eff_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            sram_a_q    <= '0;
            sram_d_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            eff_q       <= eff_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            sram_a_q    <= sram_a_d;
            sram_d_q    <= sram_d_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign sram_csn  = csn_q;
    assign sram_wen  = wen_q;
    assign sram_a    = sram_a_q;
    assign sram_d    = sram_d_q;

endmodule
